// File: rtl/aes_output_buffer.sv
// Captures a 128-bit AES result on done_i and streams it out as 32-bit words over valid/ready.
// Optional: define AES_OUT_MSW_FIRST_EN to send the most-significant word first.
module aes_output_buffer #(
  parameter int DATA_W = 128,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_i,
  input  logic [DATA_W-1:0] text_i,
  input  logic              ready_i,
  output logic [WORD_W-1:0] text_o,
  output logic              valid_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              ack_o,
  output logic              overrun_o
);
  localparam int NUM_WORDS = DATA_W / WORD_W;
  localparam int IDX_W     = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nx;
  logic [DATA_W-1:0] shadow;

  function automatic logic [WORD_W-1:0] word_sel(input logic [DATA_W-1:0] d,
                                                 input logic [IDX_W-1:0]  k);
`ifdef AES_OUT_MSW_FIRST_EN
    return d[(NUM_WORDS - 1 - int'(k)) * WORD_W +: WORD_W];
`else
    return d[int'(k) * WORD_W +: WORD_W];
`endif
  endfunction

  always_comb idx_nx = idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    ack_o <= 1'b0;
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      shadow    <= '0;
      text_o    <= '0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      busy_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (done_i) begin
            shadow  <= text_i;
            idx     <= '0;
            state   <= SEND;
            text_o  <= word_sel(text_i, IDX_W'(0));
            valid_o <= 1'b1;
            last_o  <= (NUM_WORDS == 1);
            busy_o  <= 1'b1;
          end
        end
        SEND: begin
          if (valid_o && ready_i) begin
            if (last_o) begin
              ack_o <= 1'b1;
              idx   <= '0;
              // A result landing on the final accept starts the next block without a gap.
              if (done_i) begin
                shadow  <= text_i;
                text_o  <= word_sel(text_i, IDX_W'(0));
                last_o  <= (NUM_WORDS == 1);
              end else begin
                state   <= IDLE;
                text_o  <= '0;
                valid_o <= 1'b0;
                last_o  <= 1'b0;
                busy_o  <= 1'b0;
              end
            end else begin
              idx    <= idx_nx;
              text_o <= word_sel(shadow, idx_nx);
              last_o <= (idx_nx == LAST_IDX);
            end
          end
          // Any other result arriving while a block is held is dropped and flagged.
          if (done_i && !(valid_o && ready_i && last_o))
            overrun_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_output_buffer.sv
// Directed bench for aes_output_buffer: reset, stream, backpressure, back-to-back, overrun, mid reset.
module tb_aes_output_buffer;
  logic         clk = 1'b0;
  logic         rst;
  logic         done_i;
  logic [127:0] text_i;
  logic         ready_i;
  logic [31:0]  text_o;
  logic         valid_o, last_o, busy_o, ack_o, overrun_o;

  int n_run = 0;
  int n_fail = 0;

  localparam logic [127:0] BLK  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] BLK2 = 128'hdeadbeef_cafef00d_01234567_89abcdef;

  logic [31:0] wa[4];
  logic [31:0] wb[4];

  aes_output_buffer dut (
    .clk(clk), .rst(rst), .done_i(done_i), .text_i(text_i), .ready_i(ready_i),
    .text_o(text_o), .valid_o(valid_o), .last_o(last_o), .busy_o(busy_o),
    .ack_o(ack_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_word(input string tag, input logic [31:0] w, input logic lst);
    chk({tag, ".valid"}, 32'(valid_o), 32'd1);
    chk({tag, ".text"},  text_o, w);
    chk({tag, ".last"},  32'(last_o), 32'(lst));
    chk({tag, ".busy"},  32'(busy_o), 32'd1);
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, ".valid"}, 32'(valid_o), 32'd0);
    chk({tag, ".text"},  text_o, 32'd0);
    chk({tag, ".busy"},  32'(busy_o), 32'd0);
    chk({tag, ".last"},  32'(last_o), 32'd0);
  endtask

  initial begin
`ifdef AES_OUT_MSW_FIRST_EN
    wa = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    wb = '{32'hdeadbeef, 32'hcafef00d, 32'h01234567, 32'h89abcdef};
`else
    wa = '{32'hccddeeff, 32'h8899aabb, 32'h44556677, 32'h00112233};
    wb = '{32'h89abcdef, 32'h01234567, 32'hcafef00d, 32'hdeadbeef};
`endif
    // Reset with done/ready asserted must not capture.
    rst = 1'b0; done_i = 1'b1; ready_i = 1'b1; text_i = BLK;
    step(); step();
    exp_idle("rst");
    chk("rst.ack", 32'(ack_o), 32'd0);
    chk("rst.ovr", 32'(overrun_o), 32'd0);
    rst = 1'b1; done_i = 1'b0;
    step();
    exp_idle("post_rst");

    // Stream with ready held high.
    done_i = 1'b1; text_i = BLK;
    step(); done_i = 1'b0;
    exp_word("s0", wa[0], 1'b0);
    step(); exp_word("s1", wa[1], 1'b0);
    step(); exp_word("s2", wa[2], 1'b0);
    step(); exp_word("s3", wa[3], 1'b1);
    chk("s3.ack", 32'(ack_o), 32'd0);
    step(); exp_idle("s_end");
    chk("s_end.ack", 32'(ack_o), 32'd1);
    step();
    chk("s_end2.ack", 32'(ack_o), 32'd0);

    // Backpressure on word1.
    done_i = 1'b1;
    step(); done_i = 1'b0;
    exp_word("b0", wa[0], 1'b0);
    step(); exp_word("b1", wa[1], 1'b0);
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); exp_word("b_hold", wa[1], 1'b0);
    end
    ready_i = 1'b1;
    step(); exp_word("b2", wa[2], 1'b0);
    step(); exp_word("b3", wa[3], 1'b1);
    step(); exp_idle("b_end");
    chk("b_end.ack", 32'(ack_o), 32'd1);

    // Back-to-back: new result on the final accept.
    done_i = 1'b1; text_i = BLK;
    step(); done_i = 1'b0;
    exp_word("bb0", wa[0], 1'b0);
    step(); step(); step();
    exp_word("bb3", wa[3], 1'b1);
    done_i = 1'b1; text_i = BLK2;
    step(); done_i = 1'b0;
    exp_word("bb_n0", wb[0], 1'b0);
    chk("bb_n0.ack", 32'(ack_o), 32'd1);
    chk("bb_n0.ovr", 32'(overrun_o), 32'd0);
    step(); exp_word("bb_n1", wb[1], 1'b0);
    chk("bb_n1.ack", 32'(ack_o), 32'd0);
    step(); exp_word("bb_n2", wb[2], 1'b0);
    step(); exp_word("bb_n3", wb[3], 1'b1);
    step(); exp_idle("bb_end");
    chk("bb_end.ack", 32'(ack_o), 32'd1);
    chk("bb_end.ovr", 32'(overrun_o), 32'd0);

    // Overrun: new result during word1 is dropped.
    done_i = 1'b1; text_i = BLK;
    step(); done_i = 1'b0;
    step(); exp_word("o1", wa[1], 1'b0);
    done_i = 1'b1; text_i = '1;
    step(); done_i = 1'b0;
    exp_word("o2", wa[2], 1'b0);
    chk("o2.ovr", 32'(overrun_o), 32'd1);
    step(); exp_word("o3", wa[3], 1'b1);
    step(); exp_idle("o_end");
    chk("o_end.ovr", 32'(overrun_o), 32'd1);

    // Mid-transfer reset after word1 accepted.
    done_i = 1'b1; text_i = BLK;
    step(); done_i = 1'b0;
    step(); step();
    exp_word("m2", wa[2], 1'b0);
    rst = 1'b0;
    step(); exp_idle("m_rst");
    chk("m_rst.ovr", 32'(overrun_o), 32'd0);
    rst = 1'b1; done_i = 1'b1; text_i = BLK;
    step(); done_i = 1'b0;
    exp_word("m_restart", wa[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
